multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Moore-style control FSM for the multicycle RV32I datapath. It sequences every instruction through fetch, decode, execute, memory and writeback, and waits on a ready/valid-style memory handshake. It bounds every memory wait with a timeout and traps illegal opcodes into a sticky fault state. It sits between the instruction register and the shared-memory datapath, and supersedes the single-cycle main decoder.

## Interface
- `MAX_WAIT`, default 15: maximum consecutive cycles a memory access may see `mem_ready`=0 before a timeout fault.
- `WAIT_W`, default `$clog2(MAX_WAIT+1)`: width of the wait counter (derived; not overridden).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op`  in  7  opcode field from the instruction register.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request active.
- `pc_write`  out  1  `pc_update | (branch & zero)`, gated as described below.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  load the instruction register.
- `mem_write`  out  1  store strobe.
- `read_enable`  out  1  data-load strobe.
- `reg_write`  out  1  register-file write.
- `alu_src_a`  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- `alu_src_b`  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- `alu_op`  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded.
- `result_src`  out  2  00 = ALUOut, 01 = data, 10 = ALU result.
- `imm_src`  out  2  00 = I, 01 = S, 10 = B, 11 = J; decoded combinationally from `op`.
- `fault`  out  1  sticky fault indicator.
- `fault_cause`  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, FAULT. With JALR enabled, JALR_ADR and JALR are added.
- Per-state outputs. Any output not listed is 0.
  - FETCH: `mem_req`; `alu_src_b`=10; `result_src`=10; `ir_write` and `pc_update` only in the cycle `mem_ready`=1.
  - DECODE: `alu_src_a`=01, `alu_src_b`=01 (branch target into ALUOut).
  - MEMADR: `alu_src_a`=10, `alu_src_b`=01.
  - MEMREAD: `mem_req`, `adr_src`, `read_enable`.
  - MEMWB: `result_src`=01, `reg_write`.
  - MEMWRITE: `mem_req`, `adr_src`; `mem_write` only while `mem_ready`=1.
  - EXECUTER: `alu_src_a`=10, `alu_op`=10.
  - EXECUTEI: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10.
  - ALUWB: `reg_write`.
  - BEQ: `alu_src_a`=10, `alu_op`=01, `branch`.
  - JAL: `alu_src_a`=01, `alu_src_b`=10, `pc_update`.
- DECODE transitions by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - anything else → FAULT with cause 01
- Other transitions:
  - MEMADR → MEMREAD for a load, MEMWRITE for a store.
  - MEMREAD → MEMWB on `mem_ready`.
  - MEMWRITE → FETCH on `mem_ready`.
  - EXECUTER, EXECUTEI and JAL → ALUWB.
  - MEMWB, ALUWB and BEQ → FETCH.
- Wait counter:
  - Cleared on entry to any `mem_req` state.
  - Increments each cycle with `mem_req`=1 and `mem_ready`=0.
  - When it reaches `MAX_WAIT` with `mem_ready` still 0, the FSM goes to FAULT with cause 10.
  - `mem_ready`=1 in the same cycle the count reaches `MAX_WAIT` counts as success, not a timeout.
- FAULT drives all strobes to 0, sets `fault`=1, holds `fault_cause`, and is left only by reset.

## Timing
- Reset (async assert, sync release) puts the FSM in FETCH with counter 0, `fault`=0 and `fault_cause`=00. During reset all outputs except `mem_req` are 0; `mem_req`=1 in the first cycle after release.
- Latency with zero-wait memory:
  - R/I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - BEQ: 3 cycles.
  - JAL: 4 cycles.
  - JALR: 5 cycles.
- Each wait cycle adds 1 cycle of latency.
- `imm_src` is purely combinational from `op` and is valid in every state.
- Reset asserted mid-instruction abandons it immediately; no partial `reg_write` or `mem_write` strobe is emitted after assertion.

## Configuration
- `JALR_EN` defined: opcode 1100111 goes DECODE → JALR_ADR → JALR → ALUWB.
  - JALR_ADR: rs1+imm into ALUOut (`alu_src_a`=10, `alu_src_b`=01, `imm_src`=00).
  - JALR: same outputs as JAL, so rd receives OldPC+4 and PC receives rs1+imm.
- `JALR_EN` undefined: opcode 1100111 is illegal and goes to FAULT with cause 01.

## Structure
- Package `ctrl_pkg` holds:
  - opcode constants;
  - the state enum, including the JALR states under the macro;
  - fault-cause codes;
  - the mux-select encodings for `alu_src_a`, `alu_src_b`, `result_src` and `imm_src`.
- One sub-module, `mem_wait_timer`: inputs clear, `req` and `ready`; outputs the timeout pulse. The FSM and its output logic stay in `multicycle_ctrl`.

## Test plan
- Reset, then `op`=0110011 with `mem_ready` tied 1 → FETCH, DECODE, EXECUTER, ALUWB; `reg_write`=1 only in cycle 4; `pc_write` only in cycle 1.
- Load `op`=0000011 with `mem_ready` low for 3 cycles in MEMREAD → `read_enable` held for 4 cycles; MEMWB follows; total 8 cycles.
- BEQ with `zero`=1, then BEQ with `zero`=0 → `pc_write`=1 in the BEQ state for the first only.
- Store with `mem_ready` held 0 for `MAX_WAIT`=15 cycles → FAULT with cause 10 and `mem_write` never asserted. Repeat with `mem_ready` rising on cycle 15 → success, no fault.
- `op`=1111111 → FAULT with cause 01 after DECODE; `op`=1100111 → JALR path if `JALR_EN` is defined, else cause 01.
- `rst_n` asserted in MEMWRITE while `mem_ready`=1 → `mem_write`=0 immediately; FETCH after release; `fault` cleared.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, FSM states,
// fault causes and datapath mux selects. JALR_EN adds the two JALR states.
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_FAULT
`ifdef JALR_EN
        ,
        S_JALR_ADR,
        S_JALR
`endif
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_TIMEOUT = 2'b10
    } fault_cause_t;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        logic [1:0] sel;
        sel = IMM_I;
        case (op)
            OP_STORE:  sel = IMM_S;
            OP_BRANCH: sel = IMM_B;
            OP_JAL:    sel = IMM_J;
            default:   sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller (master) and the
// datapath plus memory port (slave).
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       pc_write;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       read_enable;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic       fault;
    logic [1:0] fault_cause;

    modport master (
        input  op, zero, mem_ready,
        output mem_req, pc_write, adr_src, ir_write, mem_write, read_enable,
               reg_write, alu_src_a, alu_src_b, alu_op, result_src, imm_src,
               fault, fault_cause
    );

    modport slave (
        output op, zero, mem_ready,
        input  mem_req, pc_write, adr_src, ir_write, mem_write, read_enable,
               reg_write, alu_src_a, alu_src_b, alu_op, result_src, imm_src,
               fault, fault_cause
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Memory-wait watchdog: down-counter reloaded on clear, counts stalled request
// cycles and pulses timeout on the MAX_WAIT-th consecutive stall.
module mem_wait_timer #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic req,
    input  logic ready,
    output logic timeout
);

    localparam logic [WAIT_W-1:0] LOAD_VAL = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] left;
    logic              stall;

    assign stall = req & ~ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left <= LOAD_VAL;
        end else if (clear) begin
            left <= LOAD_VAL;
        end else if (stall && (left != '0)) begin
            left <= left - WAIT_W'(1);
        end
    end

    // Terminal count: this stall is the last one allowed; a ready in the same
    // cycle is still a success because stall is then low.
    assign timeout = stall & (left == WAIT_W'(1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle RV32I datapath with bounded memory
// waits and a sticky fault state. Define JALR_EN to add the JALR path.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   bus
);
    // state      | meaning
    // FETCH      | read instruction at PC, PC+4 into PC on mem_ready
    // DECODE     | OldPC+imm (branch target) into ALUOut, dispatch on op
    // MEMADR     | rs1+imm into ALUOut
    // MEMREAD    | load from ALUOut address, wait for mem_ready
    // MEMWB      | loaded data into rd
    // MEMWRITE   | store to ALUOut address, wait for mem_ready
    // EXECUTER   | rs1 op rs2
    // EXECUTEI   | rs1 op imm
    // ALUWB      | ALUOut into rd
    // BEQ        | compare rs1/rs2, take branch on zero
    // JAL        | OldPC+4 into ALUOut, PC from ALUOut
    // JALR_ADR   | rs1+imm into ALUOut (JALR_EN only)
    // JALR       | as JAL (JALR_EN only)
    // FAULT      | all strobes off, held until reset

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_t       state, state_next;
    fault_cause_t cause_q, cause_next;

    logic       timeout, timer_clr;
    logic       mem_req_d, adr_src_d, ir_write_d, mem_write_d;
    logic       read_en_d, reg_write_d, pc_update, branch;
    logic [1:0] src_a_d, src_b_d, alu_op_d, res_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            cause_q <= CAUSE_NONE;
        end else begin
            state   <= state_next;
            cause_q <= cause_next;
        end
    end

    always_comb begin
        state_next  = state;
        cause_next  = cause_q;
        mem_req_d   = 1'b0;
        adr_src_d   = 1'b0;
        ir_write_d  = 1'b0;
        mem_write_d = 1'b0;
        read_en_d   = 1'b0;
        reg_write_d = 1'b0;
        pc_update   = 1'b0;
        branch      = 1'b0;
        src_a_d     = SRCA_PC;
        src_b_d     = SRCB_RS2;
        alu_op_d    = ALUOP_ADD;
        res_d       = RES_ALUOUT;

        case (state)
            S_FETCH: begin
                mem_req_d = 1'b1;
                src_b_d   = SRCB_FOUR;
                res_d     = RES_ALU;
                if (bus.mem_ready) begin
                    ir_write_d = 1'b1;
                    pc_update  = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout) begin
                    state_next = S_FAULT;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                src_a_d = SRCA_OLDPC;
                src_b_d = SRCB_IMM;
                case (bus.op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECUTER;
                    OP_ITYPE:          state_next = S_EXECUTEI;
                    OP_BRANCH:         state_next = S_BEQ;
                    OP_JAL:            state_next = S_JAL;
`ifdef JALR_EN
                    OP_JALR:           state_next = S_JALR_ADR;
`endif
                    default: begin
                        state_next = S_FAULT;
                        cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                src_a_d    = SRCA_RS1;
                src_b_d    = SRCB_IMM;
                state_next = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_d = 1'b1;
                adr_src_d = 1'b1;
                read_en_d = 1'b1;
                if (bus.mem_ready) begin
                    state_next = S_MEMWB;
                end else if (timeout) begin
                    state_next = S_FAULT;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_MEMWB: begin
                res_d       = RES_DATA;
                reg_write_d = 1'b1;
                state_next  = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_d = 1'b1;
                adr_src_d = 1'b1;
                if (bus.mem_ready) begin
                    mem_write_d = 1'b1;
                    state_next  = S_FETCH;
                end else if (timeout) begin
                    state_next = S_FAULT;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_EXECUTER: begin
                src_a_d    = SRCA_RS1;
                alu_op_d   = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                src_a_d    = SRCA_RS1;
                src_b_d    = SRCB_IMM;
                alu_op_d   = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_d = 1'b1;
                state_next  = S_FETCH;
            end
            S_BEQ: begin
                src_a_d    = SRCA_RS1;
                alu_op_d   = ALUOP_SUB;
                branch     = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                src_a_d    = SRCA_OLDPC;
                src_b_d    = SRCB_FOUR;
                pc_update  = 1'b1;
                state_next = S_ALUWB;
            end
`ifdef JALR_EN
            S_JALR_ADR: begin
                src_a_d    = SRCA_RS1;
                src_b_d    = SRCB_IMM;
                state_next = S_JALR;
            end
            S_JALR: begin
                src_a_d    = SRCA_OLDPC;
                src_b_d    = SRCB_FOUR;
                pc_update  = 1'b1;
                state_next = S_ALUWB;
            end
`endif
            S_FAULT: begin
                state_next = S_FAULT;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Any state change enters a fresh wait window for the next access.
    assign timer_clr = (state_next != state);

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_mem_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clr),
        .req     (mem_req_d),
        .ready   (bus.mem_ready),
        .timeout (timeout)
    );

    // Strobes are forced low while reset is held so an abandoned access never
    // leaks a write; mem_req follows FETCH so it is up right after release.
    assign bus.mem_req     = mem_req_d;
    assign bus.pc_write    = rst_n & (pc_update | (branch & bus.zero));
    assign bus.adr_src     = rst_n & adr_src_d;
    assign bus.ir_write    = rst_n & ir_write_d;
    assign bus.mem_write   = rst_n & mem_write_d;
    assign bus.read_enable = rst_n & read_en_d;
    assign bus.reg_write   = rst_n & reg_write_d;
    assign bus.alu_src_a   = rst_n ? src_a_d  : 2'b00;
    assign bus.alu_src_b   = rst_n ? src_b_d  : 2'b00;
    assign bus.alu_op      = rst_n ? alu_op_d : 2'b00;
    assign bus.result_src  = rst_n ? res_d    : 2'b00;
    assign bus.imm_src     = imm_sel(bus.op);
    assign bus.fault       = rst_n & (state == S_FAULT);
    assign bus.fault_cause = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus randomized
// instruction streams checked against per-instruction expectations.
module tb_multicycle_ctrl;

    localparam int MAX_WAIT = 15;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_BEQ    = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BAD    = 7'b1111111;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Zero-wait cycle count of each instruction class.
    function automatic int base_lat(input logic [6:0] o);
        case (o)
            OPC_R, OPC_I, OPC_STORE, OPC_JAL: return 4;
            OPC_LOAD, OPC_JALR:               return 5;
            OPC_BEQ:                          return 3;
            default:                          return 0;
        endcase
    endfunction

    // Expected immediate format; -1 where the format is unspecified.
    function automatic int exp_imm(input logic [6:0] o);
        case (o)
            OPC_LOAD, OPC_I, OPC_JALR: return 0;
            OPC_STORE:                 return 1;
            OPC_BEQ:                   return 2;
            OPC_JAL:                   return 3;
            default:                   return -1;
        endcase
    endfunction

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        bus.op = OPC_R;
        bus.mem_ready = 1'b1;
        bus.zero = 1'b1;
        #2;
        chk({tag, ".rst_ir_write"}, 32'(bus.ir_write), 0);
        chk({tag, ".rst_pc_write"}, 32'(bus.pc_write), 0);
        chk({tag, ".rst_wr_strobes"}, 32'({bus.reg_write, bus.mem_write, bus.read_enable}), 0);
        chk({tag, ".rst_sel"}, 32'({bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src}), 0);
        chk({tag, ".rst_fault"}, 32'({bus.fault, bus.fault_cause}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk({tag, ".rel_mem_req"}, 32'(bus.mem_req), 1);
    endtask

    // fw: stalled fetch cycles, mw: stalled data-memory cycles (both < MAX_WAIT)
    task automatic run_instr(input logic [6:0] o, input logic z, input int fw, input int mw,
                             input string tag);
        bit ld, st, br, jl, jr, alu, imm_op;
        int L, ms, c_ir, c_pc, c_rw, n_ir, n_pc, n_rw, n_mw, n_re, n_req, n_flt, n_adr;
        int n_op_f, n_op_s, n_a_rs1, n_a_old, n_b_imm, n_b_four, n_res_alu, n_res_dat;
        int imm_first;
        ld = (o == OPC_LOAD);  st = (o == OPC_STORE); br = (o == OPC_BEQ);
        jl = (o == OPC_JAL);   jr = (o == OPC_JALR);
        alu = (o == OPC_R) || (o == OPC_I);
        imm_op = (o == OPC_I);
        L  = base_lat(o) + fw + ((ld || st) ? mw : 0);
        ms = fw + 4;
        {c_ir, c_pc, c_rw, n_ir, n_pc, n_rw, n_mw, n_re, n_req, n_flt, n_adr} = '0;
        {n_op_f, n_op_s, n_a_rs1, n_a_old, n_b_imm, n_b_four, n_res_alu, n_res_dat} = '0;
        imm_first = 0;
        for (int c = 1; c <= L; c++) begin
            bus.op = o;
            bus.zero = z;
            if (c <= fw + 1)
                bus.mem_ready = (c == fw + 1);
            else if ((ld || st) && c >= ms && c <= ms + mw)
                bus.mem_ready = (c == ms + mw);
            else
                bus.mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (c == 1) imm_first = int'(bus.imm_src);
            if (bus.ir_write) begin n_ir++; c_ir = c; end
            if (bus.pc_write) begin n_pc++; if (c_pc == 0) c_pc = c; end
            if (bus.reg_write) begin n_rw++; c_rw = c; end
            n_mw  += int'(bus.mem_write);
            n_re  += int'(bus.read_enable);
            n_req += int'(bus.mem_req);
            n_adr += int'(bus.adr_src);
            n_flt += int'(bus.fault);
            if (bus.alu_op == 2'b10) n_op_f++;
            if (bus.alu_op == 2'b01) n_op_s++;
            if (bus.alu_src_a == 2'b10) n_a_rs1++;
            if (bus.alu_src_a == 2'b01) n_a_old++;
            if (bus.alu_src_b == 2'b01) n_b_imm++;
            if (bus.alu_src_b == 2'b10) n_b_four++;
            if (bus.result_src == 2'b10) n_res_alu++;
            if (bus.result_src == 2'b01) n_res_dat++;
            @(posedge clk);
            #1;
        end
        chk({tag, ".ir_cnt"}, n_ir, 1);
        chk({tag, ".ir_cyc"}, c_ir, fw + 1);
        chk({tag, ".pc_cnt"}, n_pc, 1 + ((br && z) ? 1 : 0) + ((jl || jr) ? 1 : 0));
        chk({tag, ".pc_first"}, c_pc, fw + 1);
        chk({tag, ".rw_cnt"}, n_rw, (st || br) ? 0 : 1);
        if (!(st || br)) chk({tag, ".rw_cyc"}, c_rw, L);
        chk({tag, ".mw_cnt"}, n_mw, st ? 1 : 0);
        chk({tag, ".re_cnt"}, n_re, ld ? mw + 1 : 0);
        chk({tag, ".req_cnt"}, n_req, fw + 1 + ((ld || st) ? mw + 1 : 0));
        chk({tag, ".adr_cnt"}, n_adr, (ld || st) ? mw + 1 : 0);
        chk({tag, ".fault_cnt"}, n_flt, 0);
        chk({tag, ".aluop"}, {n_op_f, n_op_s}, {alu ? 32'd1 : 32'd0, br ? 32'd1 : 32'd0});
        chk({tag, ".srca"}, {n_a_rs1, n_a_old},
            {(alu || ld || st || br || jr) ? 32'd1 : 32'd0, 32'd1 + ((jl || jr) ? 32'd1 : 32'd0)});
        chk({tag, ".srcb"}, {n_b_imm, n_b_four},
            {32'(1 + ((ld || st) ? 1 : 0) + (imm_op ? 1 : 0) + (jr ? 1 : 0)),
             32'(fw + 1 + ((jl || jr) ? 1 : 0))});
        chk({tag, ".ressrc"}, {n_res_alu, n_res_dat}, {32'(fw + 1), ld ? 32'd1 : 32'd0});
        if (exp_imm(o) >= 0) chk({tag, ".imm_src"}, imm_first, exp_imm(o));
    endtask

    // Runs n_cyc cycles (fetch succeeds in cycle 1 unless low_from is 1), holding
    // mem_ready low from cycle low_from, then expects the sticky fault.
    task automatic run_fault(input logic [6:0] o, input int n_cyc, input int low_from,
                             input logic [1:0] cause, input string tag);
        int n_mw, n_flt;
        n_mw = 0; n_flt = 0;
        for (int c = 1; c <= n_cyc; c++) begin
            bus.op = o;
            bus.zero = 1'($urandom_range(0, 1));
            if (c >= low_from)  bus.mem_ready = 1'b0;
            else if (c == 1)    bus.mem_ready = 1'b1;
            else                bus.mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_mw  += int'(bus.mem_write);
            n_flt += int'(bus.fault);
            @(posedge clk);
            #1;
        end
        chk({tag, ".no_early_fault"}, n_flt, 0);
        chk({tag, ".no_mem_write"}, n_mw, 0);
        bus.mem_ready = 1'b1;
        bus.zero = 1'b1;
        @(negedge clk);
        chk({tag, ".fault"}, 32'(bus.fault), 1);
        chk({tag, ".cause"}, 32'(bus.fault_cause), 32'(cause));
        chk({tag, ".strobes_off"},
            32'({bus.mem_req, bus.pc_write, bus.ir_write, bus.mem_write, bus.read_enable, bus.reg_write}), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({tag, ".sticky"}, 32'({bus.fault, bus.fault_cause}), 32'({1'b1, cause}));
        @(posedge clk);
        #1;
    endtask

    logic [6:0] rand_ops [7];
    int n_ops;

    initial begin
        rand_ops = '{OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BEQ, OPC_JAL, OPC_JALR};
`ifdef JALR_EN
        n_ops = 7;
`else
        n_ops = 6;
`endif
        bus.op = OPC_R;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        #3;
        do_reset("init");

        run_instr(OPC_R, 1'b0, 0, 0, "rtype");
        run_instr(OPC_LOAD, 1'b0, 0, 3, "load_wait3");
        run_instr(OPC_BEQ, 1'b1, 0, 0, "beq_taken");
        run_instr(OPC_BEQ, 1'b0, 0, 0, "beq_not");
        run_instr(OPC_STORE, 1'b0, 0, MAX_WAIT - 1, "store_last_ok");
        run_instr(OPC_I, 1'b1, MAX_WAIT - 1, 0, "fetch_last_ok");
        run_instr(OPC_JAL, 1'b0, 1, 0, "jal");
`ifdef JALR_EN
        run_instr(OPC_JALR, 1'b0, 0, 0, "jalr");
`endif

        for (int i = 0; i < 40; i++) begin
            logic [6:0] o;
            int fw, mw;
            o  = rand_ops[$urandom_range(0, n_ops - 1)];
            fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MAX_WAIT - 1)) : int'($urandom_range(0, 2));
            mw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MAX_WAIT - 1)) : int'($urandom_range(0, 2));
            run_instr(o, 1'($urandom_range(0, 1)), fw, mw, $sformatf("rnd%0d", i));
        end

        do_reset("rst_a");
        run_fault(OPC_STORE, 3 + MAX_WAIT, 4, 2'b10, "store_timeout");
        do_reset("rst_b");
        run_fault(OPC_BAD, 2, 1000, 2'b01, "illegal");
`ifndef JALR_EN
        do_reset("rst_c");
        run_fault(OPC_JALR, 2, 1000, 2'b01, "jalr_illegal");
`endif
        do_reset("rst_d");
        run_fault(OPC_LOAD, MAX_WAIT, 1, 2'b10, "fetch_timeout");

        do_reset("rst_e");
        bus.op = OPC_STORE;
        for (int c = 1; c <= 3; c++) begin
            bus.mem_ready = (c == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        bus.mem_ready = 1'b1;
        #1;
        chk("midrst.mem_write_before", 32'(bus.mem_write), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst.mem_write_after", 32'(bus.mem_write), 0);
        chk("midrst.other_strobes", 32'({bus.reg_write, bus.pc_write, bus.ir_write}), 0);
        chk("midrst.fault", 32'(bus.fault), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("midrst.mem_req_release", 32'(bus.mem_req), 1);
        run_instr(OPC_R, 1'b0, 0, 0, "after_midrst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
